// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
// Holds the FSM state encoding, the owner encoding and the default parameter values.
package unified_mem_arbiter_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // The WAIT timer counts down to zero, so it is loaded with one less than the latency.
    function automatic logic [1:0] wait_load(input int mem_lat);
        return 2'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_starve.sv
// Starvation tracker: counts back-to-back data grants taken while a fetch is pending.
// starved tells the arbiter the fetch port must win the next arbitration.
module arb_starve_counter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic grant_dm,
    input  logic grant_if,
    input  logic if_req,
    output logic starved
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if || (idle && !if_req)) begin
            starve_cnt <= '0;
        end else if (grant_dm && starve_cnt < CNT_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign starved = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter shared by an instruction fetch port and a data port.
// Optional macro UNIFIED_MEM_ARBITER_STALL_CNT_EN adds the stall_cnt fetch-stall counter output.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winning request
// ACCESS | mem_en high for one cycle with the latched address/we/wdata
// WAIT   | MEM_LAT cycles of memory latency; read data captured in the last one
// RESP   | one-cycle ack to the owner, then back to IDLE
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef UNIFIED_MEM_ARBITER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [1:0] WAIT_LOAD = wait_load(MEM_LAT);

    arb_state_t        state;
    owner_t            owner;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [1:0]        wait_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic idle;
    logic starved;
    logic grant_if;
    logic grant_dm;

    // Data normally wins; a pending fetch takes over once it has been passed over STARVE_MAX times.
    assign idle     = (state == ST_IDLE);
    assign grant_if = idle && if_req && (!dm_req || starved);
    assign grant_dm = idle && dm_req && !grant_if;

    arb_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .idle     (idle),
        .grant_dm (grant_dm),
        .grant_if (grant_if),
        .if_req   (if_req),
        .starved  (starved)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            wait_cnt   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_if) begin
                        owner     <= OWN_IF;
                        lat_addr  <= if_addr;
                        lat_we    <= 1'b0;
                        lat_wdata <= '0;
                        state     <= ST_ACCESS;
                    end else if (grant_dm) begin
                        owner     <= OWN_DM;
                        lat_addr  <= dm_addr;
                        lat_we    <= dm_we;
                        lat_wdata <= dm_wdata;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        // Stores leave the load-data register untouched.
                        if (owner == OWN_IF) begin
                            if_rdata_q <= mem_rdata;
                        end else if (!lat_we) begin
                            dm_rdata_q <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == ST_ACCESS);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign if_ack   = (state == ST_RESP) && (owner == OWN_IF);
    assign dm_ack   = (state == ST_RESP) && (owner == OWN_DM);
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

`ifdef UNIFIED_MEM_ARBITER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (if_req && !if_ack && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    // Default build carries no fetch-stall instrumentation.
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share
// one request stream and are compared every cycle against a transaction-level reference model.
module tb_unified_mem_arbiter;

    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;

    logic [DW-1:0] if_rdata_w [2];
    logic [DW-1:0] dm_rdata_w [2];
    logic [DW-1:0] mem_addr_w [2];
    logic [DW-1:0] mem_wdata_w[2];
    logic [DW-1:0] mem_rdata_w[2];
    logic          if_ack_w   [2];
    logic          dm_ack_w   [2];
    logic          mem_en_w   [2];
    logic          mem_we_w   [2];
`ifdef UNIFIED_MEM_ARBITER_STALL_CNT_EN
    logic [15:0]   stall_w    [2];
`endif

    always #5 clk = ~clk;

    unified_mem_arbiter #(.DATA_W(DW), .MEM_LAT(LAT0), .STARVE_MAX(SMAX)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w[0]), .if_ack(if_ack_w[0]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_w[0]), .dm_ack(dm_ack_w[0]),
        .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0])
`ifdef UNIFIED_MEM_ARBITER_STALL_CNT_EN
        , .stall_cnt(stall_w[0])
`endif
    );

    unified_mem_arbiter #(.DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w[1]), .if_ack(if_ack_w[1]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_w[1]), .dm_ack(dm_ack_w[1]),
        .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1])
`ifdef UNIFIED_MEM_ARBITER_STALL_CNT_EN
        , .stall_cnt(stall_w[1])
`endif
    );

    // Reference model: one transaction record per instance, aged in cycles since its grant.
    bit            m_busy  [2];
    int            m_age   [2];
    bit            m_own_if[2];
    bit            m_we    [2];
    bit            m_fresh [2];
    int            m_starve[2];
    int            m_stall [2];
    logic [DW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_pend  [2];
    logic [DW-1:0] m_if_rd [2];
    logic [DW-1:0] m_dm_rd [2];
    logic [DW-1:0] m_mem   [2][256];

    // Memory driver: answers the DUT's own mem_en, data valid only in the cycle it is due.
    logic [DW-1:0] d_mem   [2][256];
    logic [DW-1:0] d_data  [2];
    int            d_pend  [2];

    bit            s_rst, s_if_req, s_dm_req, s_dm_we;
    logic [DW-1:0] s_if_addr, s_dm_addr, s_dm_wdata;
    bit            s_en[2], s_we[2], s_exp_ifack[2];
    logic [DW-1:0] s_maddr[2], s_mwdata[2];

    bit seen_if_ack[2];
    bit seen_dm_ack[2];
    bit chk_en;
    int cyc;
    int n_assert;
    int n_fail;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int idx(input logic [DW-1:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            bit e_en;
            bit e_ack;
            e_en  = m_busy[i] && (m_age[i] == 1);
            e_ack = m_busy[i] && (m_age[i] == lat_of(i) + 2);
            s_exp_ifack[i] = e_ack && m_own_if[i];
            if (chk_en) begin
                chk("mem_en", i, 32'(mem_en_w[i]), 32'(e_en));
                chk("mem_we", i, 32'(mem_we_w[i]), 32'(e_en && m_we[i]));
                if (e_en || m_fresh[i]) begin
                    chk("mem_addr", i, mem_addr_w[i], m_addr[i]);
                    chk("mem_wdata", i, mem_wdata_w[i], m_wdata[i]);
                end
                chk("if_ack", i, 32'(if_ack_w[i]), 32'(e_ack && m_own_if[i]));
                chk("dm_ack", i, 32'(dm_ack_w[i]), 32'(e_ack && !m_own_if[i]));
                chk("if_rdata", i, if_rdata_w[i], m_if_rd[i]);
                chk("dm_rdata", i, dm_rdata_w[i], m_dm_rd[i]);
                chk("ack_excl", i, 32'(if_ack_w[i] & dm_ack_w[i]), 32'd0);
`ifdef UNIFIED_MEM_ARBITER_STALL_CNT_EN
                chk("stall_cnt", i, {16'd0, stall_w[i]}, 32'(m_stall[i]));
`endif
            end
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < 2; i++) begin
            if (!s_rst) begin
                m_busy[i] = 0;  m_age[i] = 0;  m_starve[i] = 0;  m_stall[i] = 0;
                m_own_if[i] = 1; m_we[i] = 0;  m_fresh[i] = 1;
                m_addr[i] = '0;  m_wdata[i] = '0;
                m_if_rd[i] = '0; m_dm_rd[i] = '0;
            end else begin
                if (s_if_req && !s_exp_ifack[i] && m_stall[i] < 65535) m_stall[i]++;
                if (m_busy[i]) begin
                    if (m_age[i] == lat_of(i) + 1) begin
                        if (m_own_if[i]) m_if_rd[i] = m_pend[i];
                        else if (!m_we[i]) m_dm_rd[i] = m_pend[i];
                    end
                    if (m_age[i] == lat_of(i) + 2) m_busy[i] = 0;
                    else m_age[i]++;
                end else if (s_if_req || s_dm_req) begin
                    bit take_if;
                    take_if = s_if_req && (!s_dm_req || m_starve[i] == SMAX);
                    m_busy[i] = 1; m_age[i] = 1; m_fresh[i] = 0; m_own_if[i] = take_if;
                    if (take_if) begin
                        m_addr[i] = s_if_addr; m_we[i] = 0; m_wdata[i] = '0; m_starve[i] = 0;
                        m_pend[i] = m_mem[i][idx(s_if_addr)];
                    end else begin
                        m_addr[i] = s_dm_addr; m_we[i] = s_dm_we; m_wdata[i] = s_dm_wdata;
                        m_starve[i] = !s_if_req ? 0 : (m_starve[i] < SMAX ? m_starve[i] + 1 : SMAX);
                        if (s_dm_we) m_mem[i][idx(s_dm_addr)] = s_dm_wdata;
                        else m_pend[i] = m_mem[i][idx(s_dm_addr)];
                    end
                end else begin
                    m_starve[i] = 0;
                end
            end
        end
    endtask

    task automatic update_driver();
        for (int i = 0; i < 2; i++) begin
            if (!s_rst) begin
                d_pend[i] = 0;
            end else begin
                if (d_pend[i] > 0) d_pend[i]--;
                if (s_en[i]) begin
                    if (s_we[i]) begin
                        d_mem[i][idx(s_maddr[i])] = s_mwdata[i];
                    end else begin
                        d_data[i] = d_mem[i][idx(s_maddr[i])];
                        d_pend[i] = lat_of(i);
                    end
                end
            end
            mem_rdata_w[i] = (d_pend[i] == 1) ? d_data[i] : $urandom();
        end
    endtask

    // One clock cycle: check at the falling edge, sample, then advance model and driver.
    task automatic step();
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 2; i++) begin
            seen_if_ack[i] = (if_ack_w[i] === 1'b1);
            seen_dm_ack[i] = (dm_ack_w[i] === 1'b1);
            s_en[i]     = (mem_en_w[i] === 1'b1);
            s_we[i]     = (mem_we_w[i] === 1'b1);
            s_maddr[i]  = mem_addr_w[i];
            s_mwdata[i] = mem_wdata_w[i];
        end
        s_rst = rst; s_if_req = if_req; s_dm_req = dm_req; s_dm_we = dm_we;
        s_if_addr = if_addr; s_dm_addr = dm_addr; s_dm_wdata = dm_wdata;
        @(posedge clk);
        #1;
        update_model();
        update_driver();
        cyc++;
    endtask

    task automatic run_until(input bit want_if, input int max_cyc, output int ack_cyc);
        ack_cyc = -1;
        for (int k = 0; k < max_cyc; k++) begin
            step();
            if (want_if ? seen_if_ack[0] : seen_dm_ack[0]) begin
                ack_cyc = cyc - 1;
                break;
            end
        end
    endtask

    task automatic drain(input int n);
        if_req = 0;
        dm_req = 0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int t0;
        int ack_cyc;
        int n_dm;
        int n_bad;
        n_assert = 0; n_fail = 0; cyc = 0; chk_en = 0;
        rst = 0; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            mem_rdata_w[i] = '0; d_pend[i] = 0; d_data[i] = '0; s_exp_ifack[i] = 0;
            for (int k = 0; k < 256; k++) begin
                logic [DW-1:0] v;
                v = $urandom();
                m_mem[i][k] = v;
                d_mem[i][k] = v;
            end
            m_mem[i][4] = 32'h00A00093; d_mem[i][4] = 32'h00A00093;
            m_mem[i][16] = 32'h0000_1234; d_mem[i][16] = 32'h0000_1234;
        end
        step();
        step();
        rst = 1;
        chk_en = 1;
        drain(2);

        // Single fetch
        if_req = 1; if_addr = 32'h10; t0 = cyc;
        run_until(1, 20, ack_cyc);
        chk("fetch_lat", 0, 32'(ack_cyc - t0), 32'd3);
        chk("fetch_data", 0, if_rdata_w[0], 32'h00A00093);
        drain(10);

        // Simultaneous fetch and load: data first, fetch after
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h40; t0 = cyc;
        run_until(0, 20, ack_cyc);
        chk("both_dm_lat", 0, 32'(ack_cyc - t0), 32'd3);
        chk("both_dm_data", 0, dm_rdata_w[0], 32'h0000_1234);
        dm_req = 0;
        run_until(1, 20, ack_cyc);
        chk("both_if_lat", 0, 32'(ack_cyc - t0), 32'd7);
        drain(10);

        // Store leaves load data alone
        dm_req = 1; dm_we = 1; dm_addr = 32'h8; dm_wdata = 32'hDEAD; t0 = cyc;
        run_until(0, 20, ack_cyc);
        chk("store_lat", 0, 32'(ack_cyc - t0), 32'd3);
        chk("store_rdata_kept", 0, dm_rdata_w[0], 32'h0000_1234);
        dm_we = 0;
        drain(10);

        // Starvation limit: continuous data traffic with a fetch pending
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h40; n_dm = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (seen_dm_ack[0]) n_dm++;
            if (seen_if_ack[0]) break;
        end
        chk("starve_dm_acks", 0, 32'(n_dm), 32'd4);
        drain(12);

        // Reset while instance 1 (MEM_LAT=3) sits in WAIT
        dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        step();
        dm_req = 0;
        step();
        step();
        rst = 0;
        step();
        rst = 1;
        chk("rst_dm_rdata", 1, dm_rdata_w[1], 32'd0);
        n_bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (seen_dm_ack[1] || seen_if_ack[1]) n_bad++;
        end
        chk("rst_no_ack", 1, 32'(n_bad), 32'd0);

        // Randomized traffic; requests follow instance 0's handshake
        for (int k = 0; k < 600; k++) begin
            if (!if_req || seen_if_ack[0]) begin
                if_req  = ($urandom() % 4) != 0;
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!dm_req || seen_dm_ack[0]) begin
                dm_req   = ($urandom() % 4) != 0;
                dm_we    = ($urandom() % 3) == 0;
                dm_addr  = 32'($urandom_range(0, 255)) << 2;
                dm_wdata = $urandom();
            end
            rst = ($urandom() % 150) != 0;
            step();
        end
        rst = 1;
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
